// File: rtl/synchronization_client_core_if.sv
// Bundle of the barrier client's thread-request, account-message and release signals.
// The master side drives requests, network readiness and releases; the slave side is the client core.
interface synchronization_client_core_if #(
    parameter int THREAD_NUMB  = 8,
    parameter int TILE_COUNT   = 16,
    parameter int BARRIER_ID_W = 10,
    parameter int CNT_W        = 10
);
    localparam int THW   = $clog2(THREAD_NUMB);
    localparam int TW    = $clog2(TILE_COUNT);
    localparam int MSG_W = BARRIER_ID_W + CNT_W + TW;

    logic                    core_req_valid;
    logic [THW-1:0]          core_req_thread;
    logic [BARRIER_ID_W-1:0] core_req_barrier_id;
    logic [CNT_W-1:0]        core_req_cnt_setup;
    logic [THREAD_NUMB-1:0]  bc_release_val;
    logic                    acc_mess_valid;
    logic [MSG_W-1:0]        acc_mess;
    logic [TW-1:0]           acc_dest;
    logic                    net_available;
    logic                    rel_valid;
    logic [BARRIER_ID_W-1:0] rel_barrier_id;

    modport master (
        output core_req_valid, core_req_thread, core_req_barrier_id, core_req_cnt_setup,
        output net_available, rel_valid, rel_barrier_id,
        input  bc_release_val, acc_mess_valid, acc_mess, acc_dest
    );

    modport slave (
        input  core_req_valid, core_req_thread, core_req_barrier_id, core_req_cnt_setup,
        input  net_available, rel_valid, rel_barrier_id,
        output bc_release_val, acc_mess_valid, acc_mess, acc_dest
    );
endinterface

// File: rtl/synchronization_client_core.sv
// Per-tile barrier client: stalls requesting threads, sends one account message per
// request to the barrier's home tile, and wakes waiting threads on a matching release.
module synchronization_client_core #(
    parameter int THREAD_NUMB  = 8,
    parameter int TILE_COUNT   = 16,
    parameter int TILE_ID      = 0,
    parameter int BARRIER_ID_W = 10,
    parameter int CNT_W        = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    synchronization_client_core_if.slave  bus
);
    localparam int THW   = $clog2(THREAD_NUMB);
    localparam int TW    = $clog2(TILE_COUNT);
    localparam int MSG_W = BARRIER_ID_W + CNT_W + TW;
    localparam logic [TW-1:0] TILE_SRC = TW'(TILE_ID);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        WAIT    = 2'd2
    } thread_state_e;

    logic [THREAD_NUMB-1:0]                   pending_vec;
    logic [THREAD_NUMB-1:0]                   release_vec;
    logic [THREAD_NUMB-1:0][BARRIER_ID_W-1:0] id_vec;
    logic [THREAD_NUMB-1:0][CNT_W-1:0]        cnt_vec;

    logic             grant_found;
    logic [THW-1:0]   grant_idx;
    logic [THW-1:0]   rr_cand;
    logic [THW-1:0]   ptr_reg;
    logic             load_en;
    logic             msg_valid_reg;
    logic [MSG_W-1:0] msg_reg;
    logic [TW-1:0]    dest_reg;

    // First PENDING thread at or after the pointer, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_cand     = '0;
        for (int k = 0; k < THREAD_NUMB; k++) begin
            rr_cand = ptr_reg + THW'(k);
            if (!grant_found && pending_vec[rr_cand]) begin
                grant_found = 1'b1;
                grant_idx   = rr_cand;
            end
        end
    end

    assign load_en = (!msg_valid_reg || bus.net_available) && grant_found;

    for (genvar gi = 0; gi < THREAD_NUMB; gi++) begin : g_thread
        thread_state_e           state_reg;
        thread_state_e           state_next;
        logic [BARRIER_ID_W-1:0] id_reg;
        logic [CNT_W-1:0]        cnt_reg;
        logic                    release_reg;
        logic                    req_hit;
        logic                    grant_hit;
        logic                    rel_hit;

        assign req_hit   = bus.core_req_valid && (bus.core_req_thread == THW'(gi));
        assign grant_hit = load_en && (grant_idx == THW'(gi));
        assign rel_hit   = bus.rel_valid && (bus.rel_barrier_id == id_reg);

        always_comb begin
            state_next = state_reg;
            unique case (state_reg)
                IDLE:    if (req_hit)   state_next = PENDING;
                PENDING: if (grant_hit) state_next = WAIT;
                WAIT:    if (rel_hit)   state_next = IDLE;
                default:                state_next = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_reg   <= IDLE;
                release_reg <= 1'b1;
                id_reg      <= '0;
                cnt_reg     <= '0;
            end else begin
                state_reg   <= state_next;
                release_reg <= (state_next == IDLE);
                if (state_reg == IDLE && req_hit) begin
                    id_reg  <= bus.core_req_barrier_id;
                    cnt_reg <= bus.core_req_cnt_setup;
                end
            end
        end

        assign pending_vec[gi] = (state_reg == PENDING);
        assign release_vec[gi] = release_reg;
        assign id_vec[gi]      = id_reg;
        assign cnt_vec[gi]     = cnt_reg;
    end

    // Single-entry output register; payload only changes on a load, so it holds under backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msg_valid_reg <= 1'b0;
            msg_reg       <= '0;
            dest_reg      <= '0;
            ptr_reg       <= '0;
        end else if (load_en) begin
            msg_valid_reg <= 1'b1;
            msg_reg       <= {id_vec[grant_idx], cnt_vec[grant_idx], TILE_SRC};
            dest_reg      <= id_vec[grant_idx][TW-1:0];
            ptr_reg       <= grant_idx + THW'(1);
        end else if (bus.net_available) begin
            msg_valid_reg <= 1'b0;
        end
    end

    assign bus.bc_release_val = release_vec;
    assign bus.acc_mess_valid = msg_valid_reg;
    assign bus.acc_mess       = msg_reg;
    assign bus.acc_dest       = dest_reg;
endmodule

// File: tb/tb_synchronization_client_core.sv
// Bench for synchronization_client_core: directed test-plan scenarios followed by random
// traffic, all checked every cycle against a thread-status model held in the bench.
module tb_synchronization_client_core;
    localparam int THREAD_NUMB  = 8;
    localparam int TILE_COUNT   = 16;
    localparam int TILE_ID      = 3;
    localparam int BARRIER_ID_W = 10;
    localparam int CNT_W        = 10;
    localparam int THW          = 3;
    localparam int TW           = 4;
    localparam int MSG_W        = BARRIER_ID_W + CNT_W + TW;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    synchronization_client_core_if #(
        .THREAD_NUMB(THREAD_NUMB), .TILE_COUNT(TILE_COUNT),
        .BARRIER_ID_W(BARRIER_ID_W), .CNT_W(CNT_W)
    ) bus ();

    synchronization_client_core #(
        .THREAD_NUMB(THREAD_NUMB), .TILE_COUNT(TILE_COUNT), .TILE_ID(TILE_ID),
        .BARRIER_ID_W(BARRIER_ID_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: status 0 = running, 1 = request stored, 2 = message sent and waiting.
    int                      st   [THREAD_NUMB];
    logic [BARRIER_ID_W-1:0] mid  [THREAD_NUMB];
    logic [CNT_W-1:0]        mcnt [THREAD_NUMB];
    int                      mptr;
    bit                      mval;
    logic [MSG_W-1:0]        mmsg;
    logic [TW-1:0]           mdest;
    logic [BARRIER_ID_W-1:0] id_pool [6];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < THREAD_NUMB; t++) begin
            st[t]   = 0;
            mid[t]  = '0;
            mcnt[t] = '0;
        end
        mptr = 0;
        mval = 1'b0;
        mmsg = '0;
        mdest = '0;
    endtask

    task automatic model_step();
        int  old [THREAD_NUMB];
        int  g;
        int  idx;
        bit  free_slot;
        for (int t = 0; t < THREAD_NUMB; t++) old[t] = st[t];
        free_slot = !mval || bus.net_available;
        if (mval && bus.net_available)
            $display("txn sent mess=%06h dest=%0d", mmsg, mdest);
        g = -1;
        for (int k = 0; k < THREAD_NUMB; k++) begin
            idx = (mptr + k) % THREAD_NUMB;
            if (g < 0 && old[idx] == 1) g = idx;
        end
        if (bus.rel_valid)
            for (int t = 0; t < THREAD_NUMB; t++)
                if (old[t] == 2 && mid[t] == bus.rel_barrier_id) st[t] = 0;
        if (bus.core_req_valid && old[int'(bus.core_req_thread)] == 0) begin
            st[int'(bus.core_req_thread)]   = 1;
            mid[int'(bus.core_req_thread)]  = bus.core_req_barrier_id;
            mcnt[int'(bus.core_req_thread)] = bus.core_req_cnt_setup;
        end
        if (free_slot && g >= 0) begin
            st[g] = 2;
            mval  = 1'b1;
            mmsg  = {mid[g], mcnt[g], TW'(TILE_ID)};
            mdest = mid[g][TW-1:0];
            mptr  = (g + 1) % THREAD_NUMB;
        end else if (free_slot) begin
            mval = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [THREAD_NUMB-1:0] exp_bc;
        for (int t = 0; t < THREAD_NUMB; t++) exp_bc[t] = (st[t] == 0);
        check_val("bc_release_val", 64'(bus.bc_release_val), 64'(exp_bc));
        check_val("acc_mess_valid", 64'(bus.acc_mess_valid), 64'(mval));
        if (mval) begin
            check_val("acc_mess", 64'(bus.acc_mess), 64'(mmsg));
            check_val("acc_dest", 64'(bus.acc_dest), 64'(mdest));
        end
    endtask

    task automatic idle_inputs();
        bus.core_req_valid      = 1'b0;
        bus.core_req_thread     = '0;
        bus.core_req_barrier_id = '0;
        bus.core_req_cnt_setup  = '0;
        bus.rel_valid           = 1'b0;
        bus.rel_barrier_id      = '0;
    endtask

    task automatic set_req(input int thr, input int id, input int cnt);
        bus.core_req_valid      = 1'b1;
        bus.core_req_thread     = THW'(thr);
        bus.core_req_barrier_id = BARRIER_ID_W'(id);
        bus.core_req_cnt_setup  = CNT_W'(cnt);
    endtask

    task automatic set_rel(input int id);
        bus.rel_valid      = 1'b1;
        bus.rel_barrier_id = BARRIER_ID_W'(id);
    endtask

    // Inputs are set at the falling edge; one rising edge is applied, then outputs compared.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        idle_inputs();
    endtask

    task automatic async_reset();
        int nwait;
        nwait = 0;
        for (int t = 0; t < THREAD_NUMB; t++) if (st[t] == 2) nwait++;
        $display("txn reset with acc_mess_valid=%0d waiting=%0d", mval, nwait);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_val("reset_valid", 64'(bus.acc_mess_valid), 64'(0));
        check_val("reset_bc", 64'(bus.bc_release_val), 64'hFF);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bit did_mid_reset;
        int nwait;
        id_pool[0] = 10'h009; id_pool[1] = 10'h00A; id_pool[2] = 10'h00B;
        id_pool[3] = 10'h025; id_pool[4] = 10'h3F0; id_pool[5] = 10'h001;
        bus.net_available = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b1;

        // Single request with immediate network acceptance, then release.
        set_req(2, 'h25, 7);
        step();
        check_val("single_bc", 64'(bus.bc_release_val), 64'hFB);
        step();
        check_val("single_valid", 64'(bus.acc_mess_valid), 64'(1));
        check_val("single_mess", 64'(bus.acc_mess), 64'({10'h025, 10'd7, 4'd3}));
        check_val("single_dest", 64'(bus.acc_dest), 64'(5));
        step();
        check_val("single_one_cycle", 64'(bus.acc_mess_valid), 64'(0));
        set_rel('h25);
        step();
        check_val("single_release", 64'(bus.bc_release_val), 64'hFF);

        // Backpressure for five cycles, then consumption.
        bus.net_available = 1'b0;
        set_req(1, 'h33, 2);
        step();
        repeat (5) step();
        check_val("bp_held", 64'(bus.acc_mess_valid), 64'(1));
        bus.net_available = 1'b1;
        step();
        check_val("bp_consumed", 64'(bus.acc_mess_valid), 64'(0));

        // Round-robin from pointer 0 (thread 7 occupies the register to park the pointer at 0).
        async_reset();
        bus.net_available = 1'b0;
        set_req(7, 'h3F0, 1); step();
        step();
        set_req(5, 'h00B, 5); step();
        set_req(1, 'h00A, 4); step();
        set_req(0, 'h009, 3); step();
        bus.net_available = 1'b1;
        step();
        check_val("rr_first", 64'(bus.acc_mess), 64'({10'h009, 10'd3, 4'd3}));
        step();
        check_val("rr_second", 64'(bus.acc_mess), 64'({10'h00A, 10'd4, 4'd3}));
        step();
        check_val("rr_third", 64'(bus.acc_mess), 64'({10'h00B, 10'd5, 4'd3}));

        // Release arriving while the matching thread is still PENDING.
        bus.net_available = 1'b0;
        set_req(3, 'h009, 6); step();
        set_rel('h009); step();
        check_val("pend_not_released", 64'(bus.bc_release_val[3]), 64'(0));
        bus.net_available = 1'b1;
        step();
        check_val("pend_msg_sent", 64'(bus.acc_mess), 64'({10'h009, 10'd6, 4'd3}));

        // Random traffic with small id pools so releases often match, one mid-operation reset.
        did_mid_reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bus.net_available = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0)
                set_req(int'($urandom_range(0, THREAD_NUMB - 1)),
                        int'(id_pool[$urandom_range(0, 5)]), int'($urandom_range(0, 1023)));
            if ($urandom_range(0, 2) == 0)
                set_rel(int'(id_pool[$urandom_range(0, 5)]));
            step();
            nwait = 0;
            for (int t = 0; t < THREAD_NUMB; t++) if (st[t] == 2) nwait++;
            if ((!did_mid_reset && mval && nwait >= 3 && i > 200) || i == 2500) begin
                did_mid_reset = 1'b1;
                async_reset();
                bus.net_available = 1'b1;
                step();
                check_val("no_msg_after_reset", 64'(bus.acc_mess_valid), 64'(0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
